// File: rtl/int_mul_32_if.sv
// Request/status bundle for the iterative 32x32 multiplier.
// The master issues load/operands/op; the slave returns busy/done/result.
interface int_mul_32_if #(
    parameter int OPERAND_SIZE = 32
);
    logic                    load_i;
    logic [OPERAND_SIZE-1:0] multiplicand_i;
    logic [OPERAND_SIZE-1:0] multiplier_i;
    logic [1:0]              op_i;
    logic                    busy_o;
    logic                    done_o;
    logic [OPERAND_SIZE-1:0] result_o;

    modport master (
        output load_i, multiplicand_i, multiplier_i, op_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  load_i, multiplicand_i, multiplier_i, op_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/int_mul_32.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU, one bit per clock.
// Operands are reduced to magnitudes up front; the sign is reapplied in FIX.
module int_mul_32 #(
    parameter int OPERAND_SIZE = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    int_mul_32_if.slave  bus
);
    localparam int W = OPERAND_SIZE;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   acc, mplier, mcand, result;
    logic [4:0]     cntr;
    logic [1:0]     op;
    logic           neg, busy, done;
    logic           a_neg, b_neg;
    logic [W:0]     sum;
    logic [2*W-1:0] prod_fix;

    assign a_neg    = bus.multiplicand_i[W-1] & ((bus.op_i == 2'b01) | (bus.op_i == 2'b10));
    assign b_neg    = bus.multiplier_i[W-1] & (bus.op_i == 2'b01);
    assign sum      = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : (W+1)'(0));
    // Two's complement of the full 64-bit product; 0 negates to 0.
    assign prod_fix = neg ? (~{acc, mplier} + (2*W)'(1)) : {acc, mplier};

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load_i) state_nxt = CALC;
            CALC:    if (cntr == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc    <= '0;
            mplier <= '0;
            mcand  <= '0;
            cntr   <= '0;
            op     <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (bus.load_i) begin
                    op     <= bus.op_i;
                    neg    <= a_neg ^ b_neg;
                    mcand  <= a_neg ? -bus.multiplicand_i : bus.multiplicand_i;
                    mplier <= b_neg ? -bus.multiplier_i   : bus.multiplier_i;
                    acc    <= '0;
                    cntr   <= '0;
                    busy   <= 1'b1;
                end
                CALC: begin
                    // Carry out of the add lands in acc[W-1]; low bit shifts into mplier.
                    acc    <= sum[W:1];
                    mplier <= {sum[0], mplier[W-1:1]};
                    cntr   <= cntr + 5'd1;
                end
                FIX: begin
                    {acc, mplier} <= prod_fix;
                    result <= (op == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                DONE: done <= 1'b0;
                default: begin
                    acc    <= '0;
                    mplier <= '0;
                    mcand  <= '0;
                    cntr   <= '0;
                    op     <= '0;
                    neg    <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    result <= '0;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy;
    assign bus.done_o   = done;
    assign bus.result_o = result;
endmodule

// File: tb/tb_int_mul_32.sv
// Scoreboard bench for int_mul_32: directed corners, handshake/reset timing,
// and randomized ops checked against a plain 64-bit arithmetic model.
module tb_int_mul_32;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    int_mul_32_if #(.OPERAND_SIZE(32)) bus ();
    int_mul_32 #(.OPERAND_SIZE(32)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = 64'(sa * sb);
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(posedge clk_i) begin
        if (rst_ni && bus.done_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h expected no done", bus.result_o);
            end else begin
                check("result", bus.result_o, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk_i);
        bus.load_i = 1'b1;
        bus.op_i = op;
        bus.multiplicand_i = a;
        bus.multiplier_i = b;
        exp_q.push_back(ref_mul(op, a, b));
        @(posedge clk_i);
        bus.load_i = 1'b0;
    endtask

    // Called one posedge after the load was driven; lat counts posedges from the drive.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        forever begin
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) break;
            if (lat > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_timeout: got no done after %0d cycles expected 34", lat);
                break;
            end
            @(posedge clk_i);
            lat++;
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat, bc;
        issue(op, a, b);
        wait_done(lat, bc);
    endtask

    initial begin
        int lat, bc, cyc, nd, t_prev;
        logic [1:0] rop;
        bus.load_i = 1'b0;
        bus.op_i = 2'b00;
        bus.multiplicand_i = '0;
        bus.multiplier_i = '0;

        #12;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        @(posedge clk_i);
        rst_ni = 1'b1;

        // Basic MUL with latency and busy-length checks
        issue(2'b00, 32'd7, 32'd6);
        wait_done(lat, bc);
        check("basic_latency", 32'(lat), 32'd34);
        check("basic_busy_cycles", 32'(bc), 32'd33);
        check("basic_value_model", ref_mul(2'b00, 32'd7, 32'd6), 32'h2A);

        // Unsigned extremes and signed corners
        run(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b01, 32'h8000_0000, 32'h8000_0000);
        run(2'b01, 32'hFFFF_FFFF, 32'h0000_0001);
        run(2'b01, 32'h0000_0000, 32'h8000_0000);
        run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b10, 32'h0000_0002, 32'h8000_0000);
        run(2'b10, 32'h8000_0000, 32'h0000_0000);

        // load_i held high: one op per 35 cycles
        @(posedge clk_i);
        bus.load_i = 1'b1;
        bus.op_i = 2'b00;
        bus.multiplicand_i = 32'h0001_0003;
        bus.multiplier_i = 32'h0000_0101;
        repeat (3) exp_q.push_back(ref_mul(2'b00, 32'h0001_0003, 32'h0000_0101));
        cyc = 0;
        nd = 0;
        t_prev = 0;
        while (nd < 3 && cyc < 200) begin
            @(posedge clk_i);
            cyc++;
            if (bus.done_o) begin
                if (nd > 0) check("b2b_period", 32'(cyc - t_prev), 32'd35);
                else        check("b2b_first", 32'(cyc), 32'd34);
                t_prev = cyc;
                nd++;
            end
        end
        bus.load_i = 1'b0;
        if (nd < 3) begin
            n_tests++;
            n_fail++;
            $display("FAIL b2b_timeout: got %0d done pulses expected 3", nd);
        end

        // Load pulse during CALC must be ignored
        issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(posedge clk_i);
        bus.load_i = 1'b1;
        bus.op_i = 2'b00;
        bus.multiplicand_i = 32'd2;
        bus.multiplier_i = 32'd2;
        @(posedge clk_i);
        bus.load_i = 1'b0;
        wait_done(lat, bc);
        repeat (40) @(posedge clk_i);

        // Reset mid-operation, asynchronous clear
        run(2'b00, 32'h0000_1234, 32'h0000_0010);
        issue(2'b00, 32'd9, 32'd9);
        repeat (10) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.busy_o), 32'd0);
        check("async_rst_done", 32'(bus.done_o), 32'd0);
        check("async_rst_result", bus.result_o, 32'd0);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk_i);
        rst_ni = 1'b1;
        issue(2'b00, 32'd3, 32'd5);
        wait_done(lat, bc);
        check("post_rst_latency", 32'(lat), 32'd34);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       run(rop, 32'h8000_0000 | $urandom(), $urandom());
                1:       run(rop, $urandom(), 32'h8000_0000 | $urandom());
                default: run(rop, $urandom(), $urandom());
            endcase
        end

        repeat (40) @(posedge clk_i);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
